// File: rtl/score_decide.sv
// Hysteresis classifier feeding a first-word-fall-through decision FIFO.
// Define SCORE_HYSTERESIS_EN for the two-threshold FSM; otherwise a single-threshold compare.
module score_decide #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [18:0] filter_out,
    input  logic               out_sig,
    input  logic signed [18:0] thresh_hi,
    input  logic signed [18:0] thresh_lo,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic signed [18:0] dec_score,
    output logic               dec_class,
    output logic               dec_change,
    output logic               overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_LOW  = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    typedef struct packed {
        logic signed [18:0] score;
        logic               cls;
        logic               chg;
    } entry_t;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    entry_t        mem_q [DEPTH];

    entry_t wr_entry;
    entry_t head;
    logic   empty, full, do_pop, do_push;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (out_sig) begin
`ifdef SCORE_HYSTERESIS_EN
            case (state_q)
                ST_LOW:  if (filter_out >= thresh_hi) state_d = ST_HIGH;
                default: if (filter_out <  thresh_lo) state_d = ST_LOW;
            endcase
`else
            state_d = (filter_out >= thresh_hi) ? ST_HIGH : ST_LOW;
`endif
        end
    end

`ifndef SCORE_HYSTERESIS_EN
    logic unused_thresh_lo;
    assign unused_thresh_lo = ^thresh_lo;
`endif

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = !empty && dec_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = out_sig && (!full || do_pop);

        wr_entry = '{score: filter_out, cls: state_d, chg: (state_d != state_q)};

        wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        overflow_d = overflow_q || (out_sig && full && !do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOW;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; outputs are masked while empty, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        dec_valid  = !empty;
        dec_score  = empty ? '0   : head.score;
        dec_class  = empty ? 1'b0 : head.cls;
        dec_change = empty ? 1'b0 : head.chg;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_score_decide.sv
// Self-checking bench for score_decide: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_score_decide;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [18:0] filter_out;
    logic               out_sig;
    logic signed [18:0] thresh_hi;
    logic signed [18:0] thresh_lo;
    logic               dec_valid;
    logic               dec_ready;
    logic signed [18:0] dec_score;
    logic               dec_class;
    logic               dec_change;
    logic               overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    score_decide #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .filter_out (filter_out),
        .out_sig    (out_sig),
        .thresh_hi  (thresh_hi),
        .thresh_lo  (thresh_lo),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_score  (dec_score),
        .dec_class  (dec_class),
        .dec_change (dec_change),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of decisions and the last class seen.
    typedef struct {
        int score;
        bit cls;
        bit chg;
    } ent_t;

    ent_t m_q[$];
    bit   m_prev;
    bit   m_ovf;

    always @(posedge clk or posedge reset) begin
        bit   pop;
        bit   cls;
        ent_t e;
        if (reset) begin
            m_q.delete();
            m_prev = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            pop = (m_q.size() > 0) && dec_ready;
            if (pop) void'(m_q.pop_front());
            if (out_sig) begin
`ifdef SCORE_HYSTERESIS_EN
                if (!m_prev) cls = (int'(filter_out) >= int'(thresh_hi));
                else         cls = !(int'(filter_out) < int'(thresh_lo));
`else
                cls = (int'(filter_out) >= int'(thresh_hi));
`endif
                e.score = int'(filter_out);
                e.cls   = cls;
                e.chg   = (cls != m_prev);
                m_prev  = cls;
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else                    m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (cmp_en) begin
            ev = (m_q.size() > 0);
            check("cmp_valid",    dec_valid, ev);
            check("cmp_score",    $signed(dec_score), ev ? m_q[0].score : 0);
            check("cmp_class",    dec_class,  ev ? m_q[0].cls : 1'b0);
            check("cmp_change",   dec_change, ev ? m_q[0].chg : 1'b0);
            check("cmp_overflow", overflow,   m_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input int v);
        filter_out = 19'(v);
        out_sig    = 1'b1;
        step();
        out_sig    = 1'b0;
    endtask

    task automatic pop_one();
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
    endtask

    task automatic check_head(input string name, input int sc, input bit cl, input bit ch);
        check({name, "_valid"},  dec_valid, 1);
        check({name, "_score"},  $signed(dec_score), sc);
        check({name, "_class"},  dec_class, cl);
        check({name, "_change"}, dec_change, ch);
    endtask

    initial begin
        int sc35 [3];
        int cl35 [3];
        int ch35 [3];
        int drain37 [4];
        int t;
        int kind;
        sc35 = '{80, 40, 80};
`ifdef SCORE_HYSTERESIS_EN
        cl35 = '{1, 0, 0};
        ch35 = '{0, 1, 0};
`else
        cl35 = '{0, 0, 0};
        ch35 = '{1, 0, 0};
`endif
        drain37 = '{2, 3, 4, 7};

        reset = 1'b1; out_sig = 1'b0; filter_out = '0; dec_ready = 1'b0;
        thresh_hi = 19'sd100; thresh_lo = 19'sd50;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",    dec_valid, 0);
        check("rst_score",    $signed(dec_score), 0);
        check("rst_class",    dec_class, 0);
        check("rst_change",   dec_change, 0);
        check("rst_overflow", overflow, 0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        step();

        // First strobe appears on the outputs one cycle later.
        push_val(120);
        check_head("r34", 120, 1'b1, 1'b1);
        pop_one();

        push_val(80);
        push_val(40);
        push_val(80);
        for (int i = 0; i < 3; i++) begin
            check_head("r35", sc35[i], cl35[i][0], ch35[i][0]);
            pop_one();
        end
        check("r35_empty", dec_valid, 0);

        for (int i = 0; i < 5; i++) push_val(-10 - i);
        check("r36_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check("r36_score", $signed(dec_score), -10 - i);
            pop_one();
        end
        check("r36_empty", dec_valid, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r37_ovf_cleared", overflow, 0);
        for (int i = 1; i <= 4; i++) push_val(i);
        filter_out = 19'sd7;
        out_sig    = 1'b1;
        dec_ready  = 1'b1;
        step();
        out_sig    = 1'b0;
        dec_ready  = 1'b0;
        check("r37_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            check("r37_score", $signed(dec_score), drain37[i]);
            pop_one();
        end
        check("r37_empty", dec_valid, 0);

        thresh_hi = -19'sd262144;
        push_val(-262144);
        check("r38_min_class", dec_class, 1);
        pop_one();
        thresh_hi = 19'sd262143;
        push_val(262143);
        check("r38_max_class", dec_class, 1);
        pop_one();
        thresh_hi = 19'sd0;
        push_val(-1);
        check("r38_neg_class", dec_class, 0);
        pop_one();

        thresh_hi = 19'sd100;
        thresh_lo = 19'sd50;
        push_val(200);
        push_val(201);
        push_val(202);
        reset = 1'b1;
        #1;
        check("r39_valid_in_reset", dec_valid, 0);
        filter_out = 19'sd999;
        out_sig    = 1'b1;
        step();
        check("r39_valid_held", dec_valid, 0);
        out_sig = 1'b0;
        reset   = 1'b0;
        push_val(5);
        check_head("r39", 5, 1'b0, 1'b0);
        check("r39_overflow", overflow, 0);
        pop_one();
        check("r39_empty", dec_valid, 0);

        // Randomized traffic; the negedge compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                t = int'($urandom_range(0, 400)) - 200;
                thresh_hi = 19'(t);
                t = int'($urandom_range(0, 400)) - 200;
                thresh_lo = 19'(t);
            end
            reset   = ($urandom_range(0, 299) == 0);
            out_sig = ($urandom_range(0, 99) < 60);
            kind    = int'($urandom_range(0, 9));
            if (kind < 6)      t = int'($urandom_range(0, 400)) - 200;
            else if (kind < 8) t = int'(thresh_hi) + int'($urandom_range(0, 4)) - 2;
            else if (kind < 9) t = ($urandom_range(0, 1) != 0) ? 262143 : -262144;
            else               t = int'($urandom);
            filter_out = 19'(t);
            if ((c / 100) % 3 == 0) dec_ready = ($urandom_range(0, 99) < 20);
            else                    dec_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        reset     = 1'b0;
        out_sig   = 1'b0;
        dec_ready = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_decide.md
SCORE_DECIDE -- requirements
Module: score_decide

Interface
REQ-001 DEPTH, 4, number of decision entries buffered; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 filter_out  input  19  signed filter score from the upstream filter stage.
REQ-005 out_sig  input  1  one-cycle strobe marking filter_out valid; no backpressure to upstream.
REQ-006 thresh_hi  input  19  signed upper threshold; sampled on each strobe.
REQ-007 thresh_lo  input  19  signed lower threshold; sampled on each strobe.
REQ-008 dec_valid  output  1  head entry available.
REQ-009 dec_ready  input  1  consumer accepts head entry when dec_valid & dec_ready.
REQ-010 dec_score  output  19  signed score of head entry.
REQ-011 dec_class  output  1  class of head entry, 1 = HIGH.
REQ-012 dec_change  output  1  head entry's class differs from the previous strobe's class.
REQ-013 overflow  output  1  sticky: a strobe arrived while the FIFO was full.

Function
REQ-014 Classifier FSM states LOW and HIGH; it updates only on cycles with out_sig=1.
REQ-015 LOW->HIGH when filter_out >= thresh_hi (signed compare); otherwise stays LOW.
REQ-016 HIGH->LOW when filter_out < thresh_lo (signed compare); otherwise stays HIGH.
REQ-017 Entry class is the FSM state after the update on that strobe; dec_change = (new state != old state).
REQ-018 Each strobe pushes {filter_out, class, change} into a DEPTH-entry first-word-fall-through FIFO.
REQ-019 Latency: strobe in cycle N -> entry visible on dec_* outputs in cycle N+1 when the FIFO was empty.
REQ-020 dec_score/dec_class/dec_change hold stable while dec_valid=1 and dec_ready=0.
REQ-021 Pop occurs on dec_valid & dec_ready; dec_ready with dec_valid=0 has no effect.
REQ-022 Full without a pop in the same cycle: the push is dropped, overflow is set, and the FSM still updates.
REQ-023 Full with a pop in the same cycle: the push is accepted and occupancy is unchanged; overflow is not set.
REQ-024 Empty with push: dec_valid rises the next cycle; a simultaneous pop is impossible.
REQ-025 Read and write pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-026 overflow clears only on reset.
REQ-027 thresh_lo > thresh_hi is legal: the FSM behaves per REQ-015/016 without further checks.

Reset
REQ-028 reset=1 asynchronously forces FSM=LOW, FIFO empty, pointers=0, dec_valid=0, dec_score=0, dec_class=0, dec_change=0, overflow=0.
REQ-029 A strobe in a cycle where reset is asserted is discarded; operation resumes on the first clock edge after deassertion.
REQ-030 Reset mid-drain discards all buffered entries; no partial entry is ever presented.

Configuration
REQ-031 Macro SCORE_HYSTERESIS_EN.
REQ-032 Defined: the FSM behaves per REQ-015..016.
REQ-033 Undefined: class = (filter_out >= thresh_hi) on each strobe, thresh_lo is ignored, and dec_change is still computed against the previous class.

Verification
REQ-034 Reset, thresh_hi=100, thresh_lo=50; strobe 120 -> next cycle dec_valid=1, dec_score=120, dec_class=1, dec_change=1.
REQ-035 With hysteresis, after REQ-034: strobes 80, 40, 80 -> classes 1,0,0 and changes 0,1,0; without the macro -> classes 0,0,0 and changes 1,0,0.
REQ-036 dec_ready=0, 5 strobes of -10..-14 (DEPTH=4) -> overflow=1, 4 entries -10..-13 drained in order, -14 absent.
REQ-037 FIFO full, strobe 7 with dec_ready=1 in the same cycle -> overflow stays 0; 7 is the last entry drained.
REQ-038 Boundary: strobe -262144 with thresh_hi=-262144 -> class 1 (signed compare); strobe 262143 with thresh_hi=262143 -> class 1.
REQ-039 Assert reset with 3 entries queued, deassert, then strobe 5 -> dec_valid=0 during reset; the only entry afterwards is 5 with class 0; overflow=0.
